// File: rtl/swap_pipe_pkg.sv
// Shared opcodes and the saturating negate used by the operand-exchange pipeline.
package swap_pipe_pkg;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_SWAP = 2'b01,
      OP_ROTP = 2'b10,
      OP_ROTN = 2'b11
   } op_e;

   localparam int SN_MAX = 64;

   // Operand arrives sign-extended to SN_MAX bits; result packs the w-bit value
   // in [w-1:0] and the saturation flag at bit w, so callers cast to w+1 bits.
   function automatic logic [SN_MAX:0] sat_neg(input logic [SN_MAX-1:0] v,
                                               input int unsigned w);
      logic [SN_MAX-1:0] mask;
      logic [SN_MAX-1:0] mn;
      logic [SN_MAX-1:0] neg;
      logic [SN_MAX:0]   r;
      mask = (SN_MAX'(1) << w) - SN_MAX'(1);
      mn   = {SN_MAX{1'b1}} << (w - 1);
      neg  = -v;
      if (v == mn)
         r = {1'b0, mask >> 1} | ((SN_MAX + 1)'(1) << w);
      else
         r = {1'b0, neg & mask};
      return r;
   endfunction

endpackage

// File: rtl/swap_pipe_stage.sv
// One valid-tagged pipeline register; flush drops valid but leaves data in place.
module swap_pipe_stage
  #(parameter int W = 16)
   (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         flush,
   input  logic         load,
   input  logic         nxt_valid,
   input  logic [W-1:0] nxt_a,
   input  logic [W-1:0] nxt_b,
   input  logic         nxt_sat,
   output logic         valid,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic         sat
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         valid <= 1'b0;
         a     <= '0;
         b     <= '0;
         sat   <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= nxt_valid;
         a     <= nxt_a;
         b     <= nxt_b;
         sat   <= nxt_sat;
      end
   end

endmodule

// File: rtl/swap_pipe.sv
// Operand exchange (pass/swap/+-90 rotate with saturating negate) followed by
// a DEPTH-stage valid/ready pipeline whose empty stages always accept.
module swap_pipe
   import swap_pipe_pkg::*;
  #(parameter int W     = 16,
    parameter int DEPTH = 2)
   (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic         out_sat
   );

   logic [DEPTH:0]          vld;
   logic [DEPTH:0][W-1:0]   a_s;
   logic [DEPTH:0][W-1:0]   b_s;
   logic [DEPTH:0]          sat_s;
   logic [DEPTH+1:1]        adv;

   logic [W:0]   neg_a;
   logic [W:0]   neg_b;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_sat;

   assign neg_a = (W + 1)'(sat_neg(SN_MAX'(signed'(in_a)), W));
   assign neg_b = (W + 1)'(sat_neg(SN_MAX'(signed'(in_b)), W));

   always_comb begin
      op_a   = in_a;
      op_b   = in_b;
      op_sat = 1'b0;
      case (op_e'(in_op))
         OP_SWAP: begin
            op_a = in_b;
            op_b = in_a;
         end
         OP_ROTP: begin
            op_a   = neg_b[W-1:0];
            op_b   = in_a;
            op_sat = neg_b[W];
         end
         OP_ROTN: begin
            op_a   = in_b;
            op_b   = neg_a[W-1:0];
            op_sat = neg_a[W];
         end
         default: ;
      endcase
   end

   assign vld[0]   = in_valid;
   assign a_s[0]   = op_a;
   assign b_s[0]   = op_b;
   assign sat_s[0] = op_sat;

   // Ready ripples back from the consumer; any bubble breaks the chain.
   assign adv[DEPTH+1] = out_ready;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      assign adv[k] = ~vld[k] | adv[k+1];

      swap_pipe_stage #(.W(W)) u_stage (
         .clk       (clk),
         .clr_n     (clr_n),
         .flush     (flush),
         .load      (adv[k]),
         .nxt_valid (vld[k-1]),
         .nxt_a     (a_s[k-1]),
         .nxt_b     (b_s[k-1]),
         .nxt_sat   (sat_s[k-1]),
         .valid     (vld[k]),
         .a         (a_s[k]),
         .b         (b_s[k]),
         .sat       (sat_s[k])
      );
   end

   assign in_ready  = adv[1];
   assign out_valid = vld[DEPTH];
   assign out_a     = a_s[DEPTH];
   assign out_b     = b_s[DEPTH];
   assign out_sat   = sat_s[DEPTH];

endmodule

// File: tb/tb_swap_pipe.sv
// Directed bench for swap_pipe (W=16, DEPTH=2) with hand-computed expectations.
module tb_swap_pipe;

   logic        clk;
   logic        clr_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic        out_sat;

   int n_chk;
   int n_fail;

   swap_pipe #(.W(16), .DEPTH(2)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [15:0] a,
                             input logic [15:0] b, input logic s);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      if (v) begin
         chk({tag, ".a"},   32'(out_a),   32'(a));
         chk({tag, ".b"},   32'(out_b),   32'(b));
         chk({tag, ".sat"}, 32'(out_sat), 32'(s));
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      clr_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 2'b00);

      // reset state
      step();
      step();
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.a",     32'(out_a),     32'd0);
      chk("rst.b",     32'(out_b),     32'd0);
      chk("rst.sat",   32'(out_sat),   32'd0);
      @(negedge clk);
      clr_n = 1'b1;
      step();
      chk("rst.in_ready", 32'(in_ready), 32'd1);

      // all four opcodes back-to-back; first result two edges after acceptance
      drive(1'b1, 16'h1234, 16'h0F00, 2'b00);
      step();
      chk("op.lat0", 32'(out_valid), 32'd0);
      drive(1'b1, 16'h1234, 16'h0F00, 2'b01);
      step();
      expect_out("op.pass", 1'b1, 16'h1234, 16'h0F00, 1'b0);
      drive(1'b1, 16'h1234, 16'h0F00, 2'b10);
      step();
      expect_out("op.swap", 1'b1, 16'h0F00, 16'h1234, 1'b0);
      drive(1'b1, 16'h1234, 16'h0F00, 2'b11);
      step();
      expect_out("op.rotp", 1'b1, 16'hF100, 16'h1234, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      expect_out("op.rotn", 1'b1, 16'h0F00, 16'hEDCC, 1'b0);
      step();
      chk("op.drain", 32'(out_valid), 32'd0);

      // saturating negation of the most negative value
      drive(1'b1, 16'h8000, 16'h8000, 2'b10);
      step();
      drive(1'b1, 16'h8000, 16'h8000, 2'b11);
      step();
      expect_out("sat.rotp", 1'b1, 16'h7FFF, 16'h8000, 1'b1);
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      expect_out("sat.rotn", 1'b1, 16'h8000, 16'h7FFF, 1'b1);
      step();

      // backpressure: two absorbed, third refused, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 16'h0002, 2'b00);
      #1 chk("bp.rdy0", 32'(in_ready), 32'd1);
      step();
      drive(1'b1, 16'h0003, 16'h0004, 2'b01);
      #1 chk("bp.rdy1", 32'(in_ready), 32'd1);
      step();
      expect_out("bp.s1", 1'b1, 16'h0001, 16'h0002, 1'b0);
      drive(1'b1, 16'h0005, 16'h0006, 2'b00);
      #1 chk("bp.full", 32'(in_ready), 32'd0);
      step();
      expect_out("bp.hold", 1'b1, 16'h0001, 16'h0002, 1'b0);
      chk("bp.full2", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1 chk("bp.release", 32'(in_ready), 32'd1);
      step();
      expect_out("bp.s2", 1'b1, 16'h0004, 16'h0003, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      expect_out("bp.s3", 1'b1, 16'h0005, 16'h0006, 1'b0);
      step();
      chk("bp.empty", 32'(out_valid), 32'd0);

      // flush with two in flight and a new input offered the same cycle
      drive(1'b1, 16'h00A1, 16'h00B1, 2'b00);
      step();
      drive(1'b1, 16'h00A2, 16'h00B2, 2'b00);
      step();
      expect_out("fl.pre", 1'b1, 16'h00A1, 16'h00B1, 1'b0);
      flush = 1'b1;
      drive(1'b1, 16'h00A3, 16'h00B3, 2'b00);
      #1 chk("fl.in_ready", 32'(in_ready), 32'd1);
      step();
      flush = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      chk("fl.valid", 32'(out_valid), 32'd0);
      chk("fl.keep_a", 32'(out_a), 32'h00A1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl.gone", 32'(out_valid), 32'd0);
      end

      // asynchronous reset between edges during traffic
      drive(1'b1, 16'h0C01, 16'h0C02, 2'b00);
      step();
      drive(1'b1, 16'h0C03, 16'h0C04, 2'b00);
      step();
      expect_out("ar.pre", 1'b1, 16'h0C01, 16'h0C02, 1'b0);
      #2;
      clr_n = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      #1;
      chk("ar.valid", 32'(out_valid), 32'd0);
      chk("ar.a",     32'(out_a),     32'd0);
      #1 clr_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ar.gone", 32'(out_valid), 32'd0);
      end
      drive(1'b1, 16'h0D01, 16'h0D02, 2'b01);
      step();
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      expect_out("ar.post", 1'b1, 16'h0D02, 16'h0D01, 1'b0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/swap_pipe.md
# swap_pipe

Parametrised operand-exchange pipeline for the CORDIC datapath: accepts an (a, b) operand pair with a per-sample opcode, applies pass, swap or ±90° rotation with saturating negation, and delivers the result after a fixed DEPTH-cycle latency. It replaces the hard-wired two-register swap and plain flip-flops used ahead of the CORDIC iteration chain for quadrant pre-rotation. It also adds a valid/ready handshake with backpressure, a synchronous flush, and a saturation flag.

## Interface
- W, 16, operand width in bits, two's complement; W >= 2
- DEPTH, 2, number of pipeline register stages; DEPTH >= 1
- clk  in  1  clock; all state updates on the rising edge
- clr_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear; invalidates every stage
- in_valid  in  1  input pair present
- in_ready  out  1  pipeline can accept this cycle
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_op  in  2  operation: 00 pass, 01 swap, 10 rot+90, 11 rot-90
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_a  out  W  result a
- out_b  out  W  result b
- out_sat  out  1  a negation saturated for this sample

## Operation
- Operation is computed combinationally at the input and captured in stage 1. Later stages only transport the result.
- pass: (a, b). swap: (b, a). rot+90: (−b, a). rot−90: (b, −a).
- Negation is W-bit two's complement. −(−2^(W−1)) saturates to 2^(W−1)−1, and out_sat=1 for that sample. Otherwise out_sat=0.
- Each stage k holds valid_k, a_k, b_k and sat_k.
- adv_k = valid_k==0 OR adv_(k+1). adv_(DEPTH+1) = out_ready.
- Stage k loads stage k−1 when adv_k is high. Stage 0 is the input port.
- in_ready = adv_1. A transfer occurs when in_valid & in_ready.
- out_* are driven from stage DEPTH. A transfer occurs when out_valid & out_ready.
- Bubbles collapse: an empty stage always accepts, independent of downstream.
- Data in a stage with valid=0 is don't-care for checking.

## Timing
- Reset (clr_n=0, asynchronous): all valid_k=0 immediately. out_valid=0, out_a=0, out_b=0, out_sat=0. in_ready=1 from the first cycle after release.
- Latency: a sample accepted at edge n appears on out_* after edge n+DEPTH−1, i.e. visible in cycle n+DEPTH, when there is no backpressure.
- Throughput: one pair per cycle while out_ready=1.
- Backpressure: with out_ready=0, the pipeline absorbs up to DEPTH samples, then in_ready=0 combinationally in the same cycle. in_ready depends combinationally on out_ready.
- Held output: while out_valid=1 and out_ready=0, out_a, out_b and out_sat stay stable.
- flush: takes priority over every advance. At the next edge all valid_k=0, and an input presented in the same cycle is dropped. in_ready is still reported, and the dropped input counts as consumed by the source. Output data registers keep their values; only valid is cleared.
- Reset mid-operation: all in-flight samples are lost and none is emitted after release.

## Structure
- Package swap_pipe_pkg holds the opcode constants OP_PASS, OP_SWAP, OP_ROTP, OP_ROTN and the function sat_neg(W-bit) returning {sat, value}.
- Sub-module swap_pipe_stage: one valid-tagged register stage carrying a, b, sat and valid, with ports for load, flush, clk and clr_n.
- The top level instantiates DEPTH stages in a generate loop and contains the opcode logic and the adv chain.

## Test plan
- Reset: W=16, DEPTH=2, clr_n low -> out_valid=0, outs 0; after release in_ready=1.
- Opcodes: a=0x1234, b=0x0F00 with op 00/01/10/11 back-to-back, out_ready=1 -> (1234,0F00), (0F00,1234), (F100,1234), (0F00,EDCC) on consecutive cycles; the first appears 2 cycles after acceptance; sat=0.
- Saturation: a=0x8000, b=0x8000, op 10 -> (7FFF, 8000), sat=1; op 11 -> (8000, 7FFF), sat=1.
- Backpressure: out_ready=0 and 3 samples offered -> 2 accepted, third sees in_ready=0; out_ready=1 -> samples emerge in order, none lost or duplicated, outputs stable while stalled.
- Flush: 2 samples in flight with flush and in_valid asserted together -> next cycle out_valid=0 and no sample from that cycle ever emerges.
- Async reset mid-stream: clr_n pulsed low between edges during continuous traffic -> out_valid falls without a clock edge; no pre-reset sample appears afterward.
